frame_buffer_port: RTL and testbench

- Memory-side responder for the pixel read/modify/write protocol that the alpha blender initiates.
- Services read requests (pixel_number -> r/g/b returned at a fixed latency) and write requests (pixel_number + r/g/b) against a single-port synchronous pixel RAM.
- Writes are buffered in a small queue so reads always win the RAM port.
- Read-after-write hazards are resolved by forwarding from the queue; frame-end completion is signalled once all writes have retired.

---
 rtl/frame_buffer_port_if.sv | 27 ++
 rtl/frame_buffer_port.sv | 103 ++++++++++
 tb/tb_frame_buffer_port.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_port_if.sv
// frame_buffer_port_if: pixel read/write requests, frame handshake and RAM port of the frame buffer responder
interface frame_buffer_port_if #(parameter int AW = 17);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [7:0]    rd_r, rd_g, rd_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_r, wr_g, wr_b;
  logic          wr_ready;
  logic          overflow;
  logic          frame_ready;
  logic          frame_done;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_r, wr_g, wr_b, frame_ready, mem_rdata,
    input  rd_valid, rd_r, rd_g, rd_b, wr_ready, overflow, frame_done, mem_addr, mem_re, mem_we, mem_wdata
  );
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_r, wr_g, wr_b, frame_ready, mem_rdata,
    output rd_valid, rd_r, rd_g, rd_b, wr_ready, overflow, frame_done, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/frame_buffer_port.sv
// frame_buffer_port: pixel RAM responder with write queue, read forwarding and frame-done tracking
module frame_buffer_port #(
  parameter int AW         = 17,
  parameter int NUM_PIXELS = 76800,
  parameter int WQ_DEPTH   = 4
) (
  input logic clk,
  input logic reset,
  frame_buffer_port_if.slave bus
);
  localparam int PW = $clog2(WQ_DEPTH);
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wq_t;
  wq_t           wq_q [WQ_DEPTH];
  wq_t           wr_ent;
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          s1_q, s2_q, sel1_q, sel2_q, rd_valid_q, overflow_q, pend_q, done_q;
  logic          mem_re_q, mem_we_q;
  logic [23:0]   fwd1_q, fwd2_q, rd_data_q, mem_wdata_q, fwd_d;
  logic [AW-1:0] mem_addr_q;
  logic          full, rd_in, wr_in, push, pop, sel_d, pend_d, done_d;
  assign wr_ent = {bus.wr_addr, bus.wr_r, bus.wr_g, bus.wr_b};
  assign full   = cnt_q == (PW+1)'(WQ_DEPTH);
  assign rd_in  = bus.rd_en && bus.rd_addr < AW'(NUM_PIXELS);
  assign wr_in  = bus.wr_en && bus.wr_addr < AW'(NUM_PIXELS);
  assign push   = wr_in && !full;
  assign pop    = !rd_in && cnt_q != '0;
  assign cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign pend_d = pend_q || bus.frame_ready;
  assign done_d = pend_d && cnt_d == '0 && !pop && !bus.rd_en && !s1_q && !s2_q;
  // Later matches override earlier ones, so the youngest write wins; out-of-range reads return zero
  always_comb begin
    sel_d = 1'b0;
    fwd_d = '0;
    for (int i = 0; i < WQ_DEPTH; i++)
      if ((PW+1)'(i) < cnt_q && wq_q[head_q + PW'(i)].addr == bus.rd_addr) begin
        sel_d = 1'b1;
        fwd_d = wq_q[head_q + PW'(i)].data;
      end
    if (push && bus.wr_addr == bus.rd_addr) begin
      sel_d = 1'b1;
      fwd_d = wr_ent.data;
    end
    if (!rd_in) begin
      sel_d = 1'b1;
      fwd_d = '0;
    end
  end
  always_ff @(posedge clk)
    if (push) wq_q[tail_q] <= wr_ent;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      sel1_q      <= 1'b0;
      sel2_q      <= 1'b0;
      fwd1_q      <= '0;
      fwd2_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      cnt_q       <= cnt_d;
      s1_q        <= bus.rd_en;
      s2_q        <= s1_q;
      sel1_q      <= sel_d;
      sel2_q      <= sel1_q;
      fwd1_q      <= fwd_d;
      fwd2_q      <= fwd1_q;
      rd_valid_q  <= s2_q;
      rd_data_q   <= !s2_q ? '0 : sel2_q ? fwd2_q : bus.mem_rdata;
      overflow_q  <= overflow_q || (bus.wr_en && full);
      pend_q      <= pend_d && !done_d;
      done_q      <= done_d;
      mem_re_q    <= rd_in;
      mem_we_q    <= pop;
      mem_addr_q  <= rd_in ? bus.rd_addr : pop ? wq_q[head_q].addr : '0;
      mem_wdata_q <= pop ? wq_q[head_q].data : '0;
    end
  assign bus.wr_ready                  = !full;
  assign bus.rd_valid                  = rd_valid_q;
  assign {bus.rd_r, bus.rd_g, bus.rd_b} = rd_data_q;
  assign bus.overflow                  = overflow_q;
  assign bus.frame_done                = done_q;
  assign bus.mem_re                    = mem_re_q;
  assign bus.mem_we                    = mem_we_q;
  assign bus.mem_addr                  = mem_addr_q;
  assign bus.mem_wdata                 = mem_wdata_q;
endmodule

// File: tb/tb_frame_buffer_port.sv
// tb_frame_buffer_port: directed bench for frame_buffer_port with read/write scoreboards and a RAM model
module tb_frame_buffer_port;
  logic        clk = 1'b0, reset = 1'b0, ram_clr = 1'b1, pre_we = 1'b0;
  logic [9:0]  pre_a = '0;
  logic [23:0] pre_d = '0;
  int          checks = 0, fails = 0, cyc = 0, n;
  logic [23:0] ram [1024];
  logic [1023:0] wv;
  logic [23:0] exp_rd[$], exp_wd[$];
  logic [16:0] exp_wa[$];
  int          exp_rc[$];
  frame_buffer_port_if #(.AW(17)) bus();
  frame_buffer_port dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ram_clr) wv <= '0;
    else if (pre_we) begin
      ram[pre_a] <= pre_d;
      wv[pre_a]  <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      wv[bus.mem_addr[9:0]]  <= 1'b1;
    end
    bus.mem_rdata <= (bus.mem_re && wv[bus.mem_addr[9:0]]) ? ram[bus.mem_addr[9:0]] : 24'h0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_re || bus.mem_we) chk("re_we_excl", 32'(bus.mem_re & bus.mem_we), 0);
    if (bus.rd_valid) begin
      chk("rd_expected", 32'(exp_rd.size() != 0), 1);
      if (exp_rd.size() != 0) begin
        chk("rd_data", {8'h0, bus.rd_r, bus.rd_g, bus.rd_b}, {8'h0, exp_rd.pop_front()});
        chk("rd_latency", cyc, exp_rc.pop_front());
      end
    end
    if (bus.mem_we) begin
      chk("wr_expected", 32'(exp_wa.size() != 0), 1);
      if (exp_wa.size() != 0) begin
        chk("wr_addr", 32'(bus.mem_addr), 32'(exp_wa.pop_front()));
        chk("wr_data", {8'h0, bus.mem_wdata}, {8'h0, exp_wd.pop_front()});
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    bus.rd_en       = 1'b0;
    bus.wr_en       = 1'b0;
    bus.frame_ready = 1'b0;
  endtask
  task automatic rd(input logic [16:0] a, input logic [23:0] d);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    exp_rd.push_back(d);
    exp_rc.push_back(cyc + 3);
  endtask
  task automatic wr(input logic [16:0] a, input logic [23:0] d, input logic q);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    {bus.wr_r, bus.wr_g, bus.wr_b} = d;
    if (q) begin
      exp_wa.push_back(a);
      exp_wd.push_back(d);
    end
  endtask
  initial begin
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_r = '0; bus.wr_g = '0; bus.wr_b = '0; bus.frame_ready = 1'b0;
    tick();
    ram_clr = 1'b0;
    pre_a = 10'd5;
    pre_d = 24'h112233;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_mem_re", 32'(bus.mem_re), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    reset = 1'b1;
    tick();
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    rd(17'd5, 24'h112233);
    tick();
    chk("rd1_mem_re", 32'(bus.mem_re), 1);
    chk("rd1_mem_addr", 32'(bus.mem_addr), 5);
    tick();
    chk("rd1_c2_re", 32'(bus.mem_re), 0);
    tick();
    chk("rd1_c3_valid", 32'(bus.rd_valid), 1);
    tick();
    chk("rd1_c4_valid", 32'(bus.rd_valid), 0);
    wr(17'd7, 24'hAABBCC, 1'b1);
    tick();
    rd(17'd7, 24'hAABBCC);
    repeat (6) tick();
    wr(17'd8, 24'hAABBCC, 1'b1);
    rd(17'd8, 24'hAABBCC);
    repeat (6) tick();
    rd(17'd20, 24'h0); wr(17'd9, 24'h010203, 1'b1);
    tick();
    rd(17'd20, 24'h0); wr(17'd9, 24'h040506, 1'b1);
    tick();
    rd(17'd9, 24'h040506);
    tick();
    wr(17'd9, 24'h070809, 1'b1);
    repeat (7) tick();
    for (int i = 0; i < 10; i++) begin
      rd(17'(30 + i), 24'h0);
      if (i < 3) wr(17'(40 + i), 24'(24'h100000 + i), 1'b1);
      tick();
      chk("burst_no_we", 32'(bus.mem_we), 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_we", 32'(bus.mem_we), 1);
    end
    tick();
    chk("drain_idle", 32'(bus.mem_we), 0);
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      rd(17'd50, 24'h0);
      if (i < 5) wr(17'(60 + i), 24'(24'h200000 + i), i < 4);
      tick();
      if (i == 2) chk("ovf_ready3", 32'(bus.wr_ready), 1);
      if (i == 3) chk("ovf_ready_full", 32'(bus.wr_ready), 0);
      if (i == 3) chk("ovf_clear", 32'(bus.overflow), 0);
      if (i == 4) chk("ovf_set", 32'(bus.overflow), 1);
    end
    n = 0;
    repeat (8) begin
      tick();
      n += int'(bus.mem_we);
    end
    chk("ovf_we_count", n, 4);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    chk("ovf_ready_again", 32'(bus.wr_ready), 1);
    wr(17'd70, 24'h300000, 1'b1);
    tick();
    wr(17'd71, 24'h300001, 1'b1);
    bus.frame_ready = 1'b1;
    tick();
    chk("fd_we1", 32'(bus.mem_we), 1);
    chk("fd_wait1", 32'(bus.frame_done), 0);
    tick();
    chk("fd_we2", 32'(bus.mem_we), 1);
    chk("fd_wait2", 32'(bus.frame_done), 0);
    tick();
    chk("fd_pulse", 32'(bus.frame_done), 1);
    chk("fd_we_done", 32'(bus.mem_we), 0);
    tick();
    chk("fd_once", 32'(bus.frame_done), 0);
    repeat (3) tick();
    bus.frame_ready = 1'b1;
    tick();
    chk("fd_idle", 32'(bus.frame_done), 1);
    tick();
    chk("fd_idle_end", 32'(bus.frame_done), 0);
    rd(17'd80, 24'h0);
    bus.frame_ready = 1'b1;
    tick();
    rd(17'd80, 24'h0);
    bus.frame_ready = 1'b1;
    tick();
    n = 0;
    repeat (8) begin
      tick();
      n += int'(bus.frame_done);
    end
    chk("fd_merge", n, 1);
    rd(17'd76800, 24'h0);
    tick();
    chk("oor_no_re", 32'(bus.mem_re), 0);
    repeat (4) tick();
    wr(17'd76800, 24'hFFFFFF, 1'b0);
    tick();
    chk("oor_ready", 32'(bus.wr_ready), 1);
    n = 0;
    repeat (3) begin
      tick();
      n += int'(bus.mem_we);
    end
    chk("oor_no_we", n, 0);
    rd(17'd5, 24'h112233);
    wr(17'd90, 24'h400000, 1'b0);
    tick();
    rd(17'd6, 24'h0);
    tick();
    reset = 1'b0;
    #1;
    exp_rd.delete();
    exp_rc.delete();
    chk("rst2_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst2_mem_re", 32'(bus.mem_re), 0);
    chk("rst2_overflow", 32'(bus.overflow), 0);
    chk("rst2_wr_ready", 32'(bus.wr_ready), 1);
    repeat (2) tick();
    reset = 1'b1;
    n = 0;
    repeat (6) begin
      tick();
      n += int'(bus.mem_we) + int'(bus.rd_valid);
    end
    chk("rst2_quiet", n, 0);
    rd(17'd5, 24'h112233);
    repeat (5) tick();
    chk("sb_rd_empty", exp_rd.size(), 0);
    chk("sb_wr_empty", exp_wa.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
